// File: rtl/mips_debug_ctrl.sv
// Run-control and debug block for the multicycle MIPS core:
// run/halt/step, PC breakpoints and cycle/instruction counters.
module mips_debug_ctrl #(
    parameter int N            = 32,
    parameter int PCW          = 8,
    parameter int SW           = 5,
    parameter int FETCH_ST     = 0,
    parameter int NBP          = 4,
    parameter int RUN_ON_RESET = 1,
    localparam int IW          = (NBP > 1) ? $clog2(NBP) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [2:0]     cmd_op,
    input  logic [IW-1:0]  cmd_idx,
    input  logic [PCW-1:0] cmd_arg,
    input  logic [PCW-1:0] pclow,
    input  logic [SW-1:0]  state,
    output logic           cpu_en,
    output logic           halted,
    output logic           bp_hit,
    output logic [IW-1:0]  bp_idx,
    output logic [N-1:0]   cycle_count,
    output logic [N-1:0]   instr_count
);

    typedef enum logic [1:0] {
        HALTED   = 2'd0,
        RUNNING  = 2'd1,
        STEPPING = 2'd2
    } fsm_t;

    localparam logic [2:0] OP_RUN    = 3'd1;
    localparam logic [2:0] OP_HALT   = 3'd2;
    localparam logic [2:0] OP_STEP   = 3'd3;
    localparam logic [2:0] OP_SETBP  = 3'd4;
    localparam logic [2:0] OP_CLRBP  = 3'd5;
    localparam logic [2:0] OP_CLRCNT = 3'd6;

    fsm_t           fsm;
    logic           busy;
    logic           skip;
    logic [PCW-1:0] bp_addr [NBP];
    logic [NBP-1:0] bp_en;

    logic           at_fetch;
    logic           retire;
    logic           bp_match;
    logic [IW-1:0]  match_idx;
    logic           cmd_fire;
    logic           idx_ok;

    assign at_fetch  = (state == SW'(FETCH_ST));
    assign retire    = at_fetch & busy;
    assign cmd_ready = (fsm != STEPPING);
    assign cmd_fire  = cmd_valid & cmd_ready;
    assign idx_ok    = (int'(cmd_idx) < NBP);

    // Breakpoint compare; scanning downward lets the lowest index win.
    always_comb begin
        bp_match  = 1'b0;
        match_idx = '0;
        for (int i = NBP - 1; i >= 0; i--) begin
            if (bp_en[i] && bp_addr[i] == pclow) begin
                bp_match  = 1'b1;
                match_idx = IW'(i);
            end
        end
        if (!at_fetch || skip)
            bp_match = 1'b0;
    end

    // Core enable: gated at a breakpoint fetch or at the end of a step.
    always_comb begin
        cpu_en = 1'b0;
        unique case (fsm)
            HALTED:   cpu_en = 1'b0;
            RUNNING:  cpu_en = !bp_match;
            STEPPING: cpu_en = !retire;
            default:  cpu_en = 1'b0;
        endcase
    end

    // Run-control FSM with instruction tracking and resume-skip flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if (RUN_ON_RESET != 0) begin
                fsm    <= RUNNING;
                halted <= 1'b0;
            end else begin
                fsm    <= HALTED;
                halted <= 1'b1;
            end
            busy   <= 1'b0;
            skip   <= 1'b0;
            bp_hit <= 1'b0;
            bp_idx <= '0;
        end else begin
            if (retire)
                busy <= 1'b0;
            else if (cpu_en && !at_fetch)
                busy <= 1'b1;
            if (cpu_en && !at_fetch)
                skip <= 1'b0;
            unique case (fsm)
                RUNNING: begin
                    if (bp_match) begin
                        fsm    <= HALTED;
                        halted <= 1'b1;
                        bp_hit <= 1'b1;
                        bp_idx <= match_idx;
                    end else if (cmd_fire && cmd_op == OP_HALT) begin
                        fsm    <= HALTED;
                        halted <= 1'b1;
                    end
                end
                STEPPING: begin
                    if (retire) begin
                        fsm    <= HALTED;
                        halted <= 1'b1;
                    end
                end
                HALTED: begin
                    if (cmd_fire && cmd_op == OP_RUN) begin
                        fsm    <= RUNNING;
                        halted <= 1'b0;
                        bp_hit <= 1'b0;
                        skip   <= 1'b1;
                    end else if (cmd_fire && cmd_op == OP_STEP) begin
                        fsm    <= STEPPING;
                        halted <= 1'b0;
                        bp_hit <= 1'b0;
                        skip   <= 1'b1;
                    end
                end
                default: begin
                    fsm    <= HALTED;
                    halted <= 1'b1;
                end
            endcase
        end
    end

    // Breakpoint table updates from the host.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bp_en <= '0;
            for (int i = 0; i < NBP; i++)
                bp_addr[i] <= '0;
        end else if (cmd_fire && idx_ok) begin
            if (cmd_op == OP_SETBP) begin
                bp_addr[cmd_idx] <= cmd_arg;
                bp_en[cmd_idx]   <= 1'b1;
            end else if (cmd_op == OP_CLRBP) begin
                bp_en[cmd_idx] <= 1'b0;
            end
        end
    end

    // Cycle and retired-instruction counters; clear beats increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else if (cmd_fire && cmd_op == OP_CLRCNT) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (cpu_en)
                cycle_count <= cycle_count + N'(1);
            if (retire)
                instr_count <= instr_count + N'(1);
        end
    end

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Directed-vector bench for mips_debug_ctrl: run, breakpoint,
// step, halt mid-instruction, reset mid-step and counter wrap.
module tb_mips_debug_ctrl;

    localparam logic [2:0] NOP    = 3'd0;
    localparam logic [2:0] RUN    = 3'd1;
    localparam logic [2:0] HALT   = 3'd2;
    localparam logic [2:0] STEP   = 3'd3;
    localparam logic [2:0] SETBP  = 3'd4;
    localparam logic [2:0] CLRBP  = 3'd5;
    localparam logic [2:0] CLRCNT = 3'd6;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_idx;
    logic [7:0]  cmd_arg;
    logic [7:0]  pclow;
    logic [4:0]  state;
    logic        cpu_en;
    logic        halted;
    logic        bp_hit;
    logic [1:0]  bp_idx;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;

    logic        w_rst;
    logic        w_ready;
    logic        w_en;
    logic        w_halted;
    logic        w_hit;
    logic [1:0]  w_idx;
    logic [3:0]  w_cyc;
    logic [3:0]  w_ins;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mips_debug_ctrl dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_arg(cmd_arg),
        .pclow(pclow), .state(state),
        .cpu_en(cpu_en), .halted(halted),
        .bp_hit(bp_hit), .bp_idx(bp_idx),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    mips_debug_ctrl #(.N(4)) u_w (
        .clk(clk), .reset(w_rst),
        .cmd_valid(1'b0), .cmd_ready(w_ready),
        .cmd_op(3'd0), .cmd_idx(2'd0), .cmd_arg(8'd0),
        .pclow(8'd0), .state(5'd1),
        .cpu_en(w_en), .halted(w_halted),
        .bp_hit(w_hit), .bp_idx(w_idx),
        .cycle_count(w_cyc), .instr_count(w_ins)
    );

    typedef struct {
        logic        cv;
        logic [2:0]  op;
        logic [1:0]  idx;
        logic [7:0]  arg;
        logic [4:0]  st;
        logic [7:0]  pc;
        logic        en;
        logic        h;
        logic        rdy;
        logic        bh;
        logic [1:0]  bi;
        logic [31:0] cyc;
        logic [31:0] ins;
    } vec_t;

    vec_t vt [38];

    function automatic vec_t r(
        logic cv, logic [2:0] op, logic [1:0] idx, logic [7:0] arg,
        logic [4:0] st, logic [7:0] pc,
        logic en, logic h, logic rdy, logic bh, logic [1:0] bi,
        logic [31:0] cyc, logic [31:0] ins);
        vec_t v;
        v.cv = cv; v.op = op; v.idx = idx; v.arg = arg;
        v.st = st; v.pc = pc;
        v.en = en; v.h = h; v.rdy = rdy; v.bh = bh; v.bi = bi;
        v.cyc = cyc; v.ins = ins;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    task automatic drive(input logic cv, input logic [2:0] op,
                         input logic [1:0] idx, input logic [7:0] arg,
                         input logic [4:0] st, input logic [7:0] pc);
        cmd_valid = cv; cmd_op = op; cmd_idx = idx; cmd_arg = arg;
        state = st; pclow = pc;
    endtask

    initial begin
        // run from reset, breakpoint at 0x10
        vt[0]  = r(0, NOP,   0, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0,  0, 0);
        vt[1]  = r(0, NOP,   0, 8'h00, 1, 8'h00, 1, 0, 1, 0, 0,  1, 0);
        vt[2]  = r(0, NOP,   0, 8'h00, 2, 8'h00, 1, 0, 1, 0, 0,  2, 0);
        vt[3]  = r(0, NOP,   0, 8'h00, 0, 8'h00, 1, 0, 1, 0, 0,  3, 0);
        vt[4]  = r(1, SETBP, 1, 8'h10, 0, 8'h00, 1, 0, 1, 0, 0,  4, 1);
        vt[5]  = r(0, NOP,   0, 8'h00, 1, 8'h10, 1, 0, 1, 0, 0,  5, 1);
        vt[6]  = r(0, NOP,   0, 8'h00, 2, 8'h10, 1, 0, 1, 0, 0,  6, 1);
        vt[7]  = r(0, NOP,   0, 8'h00, 0, 8'h10, 0, 0, 1, 0, 0,  7, 1);
        vt[8]  = r(0, NOP,   0, 8'h00, 0, 8'h10, 0, 1, 1, 1, 1,  7, 2);
        // resume past the breakpoint, hit it again
        vt[9]  = r(1, RUN,   0, 8'h00, 0, 8'h10, 0, 1, 1, 1, 1,  7, 2);
        vt[10] = r(0, NOP,   0, 8'h00, 0, 8'h10, 1, 0, 1, 0, 1,  7, 2);
        vt[11] = r(0, NOP,   0, 8'h00, 1, 8'h14, 1, 0, 1, 0, 1,  8, 2);
        vt[12] = r(0, NOP,   0, 8'h00, 2, 8'h14, 1, 0, 1, 0, 1,  9, 2);
        vt[13] = r(0, NOP,   0, 8'h00, 0, 8'h14, 1, 0, 1, 0, 1, 10, 2);
        vt[14] = r(0, NOP,   0, 8'h00, 1, 8'h14, 1, 0, 1, 0, 1, 11, 3);
        vt[15] = r(0, NOP,   0, 8'h00, 0, 8'h10, 0, 0, 1, 0, 1, 12, 3);
        // single step 0,1,2,3,0
        vt[16] = r(1, STEP,  0, 8'h00, 0, 8'h10, 0, 1, 1, 1, 1, 12, 4);
        vt[17] = r(0, NOP,   0, 8'h00, 0, 8'h10, 1, 0, 0, 0, 1, 12, 4);
        vt[18] = r(0, NOP,   0, 8'h00, 1, 8'h10, 1, 0, 0, 0, 1, 13, 4);
        vt[19] = r(0, NOP,   0, 8'h00, 2, 8'h10, 1, 0, 0, 0, 1, 14, 4);
        vt[20] = r(0, NOP,   0, 8'h00, 3, 8'h10, 1, 0, 0, 0, 1, 15, 4);
        vt[21] = r(0, NOP,   0, 8'h00, 0, 8'h18, 0, 0, 0, 0, 1, 16, 4);
        // halt mid-instruction, finish it with a step
        vt[22] = r(1, RUN,   0, 8'h00, 0, 8'h18, 0, 1, 1, 0, 1, 16, 5);
        vt[23] = r(0, NOP,   0, 8'h00, 0, 8'h18, 1, 0, 1, 0, 1, 16, 5);
        vt[24] = r(0, NOP,   0, 8'h00, 1, 8'h18, 1, 0, 1, 0, 1, 17, 5);
        vt[25] = r(1, HALT,  0, 8'h00, 2, 8'h18, 1, 0, 1, 0, 1, 18, 5);
        vt[26] = r(0, NOP,   0, 8'h00, 3, 8'h18, 0, 1, 1, 0, 1, 19, 5);
        vt[27] = r(1, STEP,  0, 8'h00, 3, 8'h18, 0, 1, 1, 0, 1, 19, 5);
        vt[28] = r(0, NOP,   0, 8'h00, 3, 8'h18, 1, 0, 0, 0, 1, 19, 5);
        vt[29] = r(0, NOP,   0, 8'h00, 0, 8'h18, 0, 0, 0, 0, 1, 20, 5);
        vt[30] = r(0, NOP,   0, 8'h00, 0, 8'h18, 0, 1, 1, 0, 1, 20, 6);
        // counter clear, breakpoint clear
        vt[31] = r(1, CLRCNT,0, 8'h00, 0, 8'h18, 0, 1, 1, 0, 1, 20, 6);
        vt[32] = r(1, CLRBP, 1, 8'h00, 0, 8'h18, 0, 1, 1, 0, 1,  0, 0);
        vt[33] = r(1, RUN,   0, 8'h00, 0, 8'h18, 0, 1, 1, 0, 1,  0, 0);
        vt[34] = r(0, NOP,   0, 8'h00, 0, 8'h18, 1, 0, 1, 0, 1,  0, 0);
        vt[35] = r(0, NOP,   0, 8'h00, 1, 8'h18, 1, 0, 1, 0, 1,  1, 0);
        vt[36] = r(0, NOP,   0, 8'h00, 0, 8'h10, 1, 0, 1, 0, 1,  2, 0);
        vt[37] = r(0, NOP,   0, 8'h00, 1, 8'h10, 1, 0, 1, 0, 1,  3, 1);

        reset = 1'b0;
        w_rst = 1'b0;
        drive(0, NOP, 0, 8'h00, 0, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst halted", 32'(halted), 0);
        chk("rst bp_hit", 32'(bp_hit), 0);
        chk("rst bp_idx", 32'(bp_idx), 0);
        chk("rst cycles", cycle_count, 0);
        chk("rst instrs", instr_count, 0);
        chk("rst ready",  32'(cmd_ready), 1);

        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 38; i++) begin
            drive(vt[i].cv, vt[i].op, vt[i].idx, vt[i].arg,
                  vt[i].st, vt[i].pc);
            @(negedge clk);
            chk($sformatf("v%0d cpu_en", i), 32'(cpu_en), 32'(vt[i].en));
            chk($sformatf("v%0d halted", i), 32'(halted), 32'(vt[i].h));
            chk($sformatf("v%0d ready", i), 32'(cmd_ready), 32'(vt[i].rdy));
            chk($sformatf("v%0d bp_hit", i), 32'(bp_hit), 32'(vt[i].bh));
            chk($sformatf("v%0d bp_idx", i), 32'(bp_idx), 32'(vt[i].bi));
            chk($sformatf("v%0d cycles", i), cycle_count, vt[i].cyc);
            chk($sformatf("v%0d instrs", i), instr_count, vt[i].ins);
            @(posedge clk);
            #1;
        end

        // reset asserted in the middle of a step
        drive(1, SETBP, 0, 8'h20, 2, 8'h00);
        @(posedge clk);
        #1 drive(1, HALT, 0, 8'h00, 3, 8'h00);
        @(posedge clk);
        #1 drive(1, STEP, 0, 8'h00, 3, 8'h00);
        @(posedge clk);
        #1 drive(0, NOP, 0, 8'h00, 3, 8'h00);
        @(negedge clk);
        chk("mid-step ready", 32'(cmd_ready), 0);
        chk("mid-step cpu_en", 32'(cpu_en), 1);
        #1 reset = 1'b0;
        #1;
        chk("arst halted", 32'(halted), 0);
        chk("arst ready",  32'(cmd_ready), 1);
        chk("arst cycles", cycle_count, 0);
        chk("arst instrs", instr_count, 0);
        chk("arst bp_hit", 32'(bp_hit), 0);
        chk("arst cpu_en", 32'(cpu_en), 1);
        @(posedge clk);
        #1 reset = 1'b1;
        drive(0, NOP, 0, 8'h00, 0, 8'h20);
        @(negedge clk);
        chk("arst bp cleared", 32'(cpu_en), 1);

        // 4-bit counter wrap
        @(posedge clk);
        #1 w_rst = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("wrap max", 32'(w_cyc), 32'd15);
        @(posedge clk);
        @(negedge clk);
        chk("wrap zero", 32'(w_cyc), 32'd0);
        chk("wrap instrs", 32'(w_ins), 32'd0);
        chk("wrap halted", 32'(w_halted), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_debug_ctrl.md
Name: mips_debug_ctrl

Overview:
- Parametrised run-control and debug block that sits between the system top and the multicycle MIPS core.
- Generates the core clock-enable `cpu_en`.
- Supports run, halt and single-step, plus up to NBP PC breakpoints.
- Maintains cycle and retired-instruction counters.
- A host drives it through a valid/ready command port.
- It extends the existing passive `pclow`/`state` observation into active control.

Parameters:
- N, 32, counter width.
- PCW, 8, width of observed PC bits and breakpoint compare.
- SW, 5, width of core state code.
- FETCH_ST, 0, state code of the core's instruction-fetch state (instruction boundary).
- NBP, 4, number of breakpoint comparators (1..16).
- RUN_ON_RESET, 1, 1 = leave reset in RUNNING, 0 = leave reset in HALTED.

Ports:
- clk, input, 1, system clock; all flops on the rising edge.
- reset, input, 1, asynchronous active-low reset.
- cmd_valid, input, 1, command present.
- cmd_ready, output, 1, command accepted when valid & ready.
- cmd_op, input, 3, 0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 SETBP, 5 CLRBP, 6 CLRCNT, 7 reserved (NOP).
- cmd_idx, input, $clog2(NBP) (min 1), breakpoint index for SETBP/CLRBP.
- cmd_arg, input, PCW, breakpoint address for SETBP.
- pclow, input, PCW, core PC low bits.
- state, input, SW, core multicycle state.
- cpu_en, output, 1, core advance enable (combinational).
- halted, output, 1, FSM in HALTED.
- bp_hit, output, 1, last halt caused by a breakpoint.
- bp_idx, output, $clog2(NBP), index of the breakpoint that hit.
- cycle_count, output, N, cycles with cpu_en=1.
- instr_count, output, N, retired instructions.

Behaviour:
- Reset: asserting reset (reset=0) clears everything immediately, including mid-instruction or mid-step. Reset values:
  - FSM = RUNNING if RUN_ON_RESET else HALTED.
  - All breakpoints disabled, addresses 0.
  - busy=0, skip=0, bp_hit=0, bp_idx=0.
  - Counters 0.
- Signal definitions:
  - at_fetch = (state==FETCH_ST).
  - busy: set when cpu_en=1 and state!=FETCH_ST; cleared on retire.
  - retire = at_fetch & busy; one per instruction.
  - bp_match = at_fetch & skip=0 & any enabled bp[i]==pclow. The lowest matching i wins.
- FSM states: HALTED, RUNNING, STEPPING.
- cpu_en by state:
  - HALTED: 0.
  - RUNNING: !bp_match.
  - STEPPING: !retire.
- RUNNING and bp_match:
  - cpu_en=0 in that cycle; the core does not execute the fetch.
  - Next state HALTED; bp_hit<=1; bp_idx<=i.
- STEPPING and retire:
  - cpu_en=0 in that cycle; next state HALTED.
  - Exactly one instruction executes per STEP.
- skip flag:
  - Set when RUN or STEP is accepted while HALTED.
  - Cleared the first cycle cpu_en=1 and state!=FETCH_ST.
  - Purpose: resuming from a breakpoint executes that instruction instead of re-hitting it.
- Command handshake:
  - cmd_ready = (FSM!=STEPPING).
  - Commands take effect on the edge where valid&ready.
- Command effects:
  - RUN: from HALTED, go RUNNING and clear bp_hit. No-op in RUNNING.
  - HALT: go HALTED next cycle. Halting mid-instruction is legal; busy is preserved, so the next resume completes that instruction.
  - STEP: from HALTED, go STEPPING and clear bp_hit. Ignored in RUNNING.
  - SETBP: bp[idx]<=arg, en<=1. CLRBP: en[idx]<=0. Both are legal in any accepting state. A SETBP that matches in the same cycle takes effect the next cycle.
  - CLRCNT: both counters <=0. Same-cycle increments are lost.
- Counters:
  - cycle_count += 1 every cycle cpu_en=1.
  - instr_count += 1 on each retire, counted in every mode including the step-ending cycle.
  - Both wrap modulo 2^N silently.
- Retire and bp_match in the same cycle (RUNNING): instr_count increments and the halt occurs.
- halted = (FSM==HALTED), registered.

Test Plan:
- Reset with RUN_ON_RESET=1, state cycling 0,1,2,0 → cpu_en=1 throughout, instr_count=1 after the return to 0, cycle_count=3, halted=0.
- SETBP idx=1 arg=0x10; core reaches state=0, pclow=0x10 → cpu_en=0 that cycle, halted=1, bp_hit=1, bp_idx=1; counters freeze.
- From that halt, RUN → core executes 0x10 (no immediate re-hit), then runs on; bp_hit=0. When PC returns to 0x10, it halts again.
- HALTED, STEP with state sequence 0,1,2,3,0 → cpu_en=1 for 4 cycles, 0 on the returning 0; instr_count +1; cmd_ready=0 during the step, 1 after.
- RUNNING, HALT accepted while state=2 → cpu_en=0 next cycle; a later STEP completes that instruction, with instr_count +1 only once.
- Reset pulsed mid-STEP, and a force of cycle_count=2^N−1 followed by one enabled cycle → all outputs at reset values; the counter wraps to 0.
